// File: rtl/tsn_rst_pkg.sv
// Shared definitions for the staged reset sequencer: FSM encoding, stage-index
// width and the default pulse/gap timing used by the TSN switch top level.
package tsn_rst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } rst_state_e;

    // Wide enough to index up to 8 staged reset outputs.
    localparam int STG_IDX_W     = 3;

    localparam int DEF_PULSE_CYC = 16;
    localparam int DEF_STAGE_GAP = 8;
    localparam int DEF_STAGES    = 3;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/rstseq_hold_filter.sv
// Hold-input conditioner: 2-FF synchronizer followed by a 4-sample filter.
// Only compiled when RSTSEQ_HOLD_FILTER_EN is defined.
`ifdef RSTSEQ_HOLD_FILTER_EN
module rstseq_hold_filter
    import tsn_rst_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_hold,
    output logic o_hold
);

    logic [1:0] sync_q;
    logic [2:0] hist_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[0], i_hold};
            hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    // Asserts only once the synchronized hold has been high for four samples;
    // a single low sample drops it immediately.
    assign o_hold = sync_q[1] & (&hist_q);

endmodule
`endif

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: minimum-width assertion, ascending staged release,
// busy/done handshake. RSTSEQ_HOLD_FILTER_EN enables the hold-input filter.
module reset_sequencer
    import tsn_rst_pkg::*;
#(
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int STAGES    = DEF_STAGES,
    parameter int STAGE_GAP = DEF_STAGE_GAP,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic [STAGES-1:0] o_rst_n_stage
);

    localparam logic [CNT_W-1:0]     PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_IDX_W-1:0] IDX_LAST   = STG_IDX_W'(STAGES - 1);

    rst_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [STG_IDX_W-1:0]  idx_q, idx_d;
    logic [STAGES-1:0]     rst_n_q, rst_n_d;
    logic [STG_IDX_W-1:0]  idx_nxt;
    logic                  hold_eff;

`ifdef RSTSEQ_HOLD_FILTER_EN
    rstseq_hold_filter u_hold_filt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_hold (i_hold),
        .o_hold (hold_eff)
    );
`else
    assign hold_eff = i_hold;
`endif

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        case (state_q)
            ST_IDLE: begin
                rst_n_d = '1;
                if (i_req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_n_d = '0;
                end
            end
            ST_ASSERT: begin
                rst_n_d = '0;
                idx_d   = '0;
                // Any request or hold restarts the full minimum width.
                if (i_req || hold_eff) begin
                    cnt_d = '0;
                end else if (cnt_q == PULSE_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    rst_n_d = STAGES'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (i_req || hold_eff) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_n_d = '0;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_nxt;
                    rst_n_d = rst_n_q | (STAGES'(1) << idx_nxt);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                cnt_d = '0;
                if (i_req) begin
                    state_d = ST_ASSERT;
                    idx_d   = '0;
                    rst_n_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
                idx_d   = '0;
                rst_n_d = '0;
            end
        endcase
    end

    // Reset lands in ASSERT so power-up runs a full sequence without a request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_DONE);
    assign o_rst_n_stage = rst_n_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (PULSE_CYC=16, STAGES=3, STAGE_GAP=8).
module tb_reset_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_req;
    logic       i_hold;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_rst_n_stage;

    int total = 0;
    int bad   = 0;

    int rise_at [3];
    int rise_cnt[3];
    int fall0_at;
    int done_at;
    int done_first;
    int done_cnt;
    int busy_fall;
    int stg_at0;

    reset_sequencer #(
        .PULSE_CYC (16),
        .STAGES    (3),
        .STAGE_GAP (8),
        .CNT_W     (8)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         (i_req),
        .i_hold        (i_hold),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_rst_n_stage (o_rst_n_stage)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Sample cycles T+0..T+ncyc; inputs set at index i are sampled at the edge
    // ending cycle T+i.
    task automatic observe(input int ncyc, input int req_at,
                           input int hold_from, input int hold_to);
        logic [2:0] prev;
        prev = 3'b000;
        for (int k = 0; k < 3; k++) begin
            rise_at[k]  = -1;
            rise_cnt[k] = 0;
        end
        fall0_at   = -1;
        done_at    = -1;
        done_first = -1;
        done_cnt   = 0;
        busy_fall  = -1;
        stg_at0    = -1;
        for (int i = 0; i <= ncyc; i++) begin
            if (i == 0) stg_at0 = int'(o_rst_n_stage);
            for (int k = 0; k < 3; k++) begin
                if (o_rst_n_stage[k] && !prev[k]) begin
                    rise_at[k] = i;
                    rise_cnt[k]++;
                end
            end
            if (!o_rst_n_stage[0] && prev[0]) fall0_at = i;
            if (o_done) begin
                if (done_cnt == 0) done_first = i;
                done_at = i;
                done_cnt++;
            end
            if (!o_busy && busy_fall < 0) busy_fall = i;
            prev   = o_rst_n_stage;
            i_req  = (i == req_at);
            i_hold = (i >= hold_from && i <= hold_to);
            tick();
        end
        i_req  = 1'b0;
        i_hold = 1'b0;
    endtask

    task automatic start_req();
        i_req = 1'b1;
        tick();
        i_req = 1'b0;
    endtask

    initial begin
        i_rst  = 1'b1;
        i_req  = 1'b0;
        i_hold = 1'b0;
        repeat (3) tick();
        check("rst_stages", int'(o_rst_n_stage), 0);
        check("rst_busy", int'(o_busy), 1);
        check("rst_done", int'(o_done), 0);
        i_rst = 1'b0;

        // Power-up sequence: T is the cycle after the last reset edge.
        observe(40, -1, -1, -1);
        check("pu_rise0", rise_at[0], 16);
        check("pu_rise1", rise_at[1], 24);
        check("pu_rise2", rise_at[2], 32);
        check("pu_done_at", done_at, 33);
        check("pu_done_cnt", done_cnt, 1);
        check("pu_busy_fall", busy_fall, 34);
        check("idle_stages", int'(o_rst_n_stage), 7);
        check("idle_busy", int'(o_busy), 0);

        // Single-cycle request from IDLE.
        start_req();
        observe(40, -1, -1, -1);
        check("req_stages_t0", stg_at0, 0);
        check("req_rise0", rise_at[0], 16);
        check("req_rise1", rise_at[1], 24);
        check("req_rise2", rise_at[2], 32);
        check("req_done_at", done_at, 33);
        check("req_busy_fall", busy_fall, 34);

`ifdef RSTSEQ_HOLD_FILTER_EN
        // A 3-cycle hold pulse never survives the filter.
        start_req();
        observe(40, -1, 5, 7);
        check("flt_rise0", rise_at[0], 16);
        check("flt_rise0_cnt", rise_cnt[0], 1);
        check("flt_rise2", rise_at[2], 32);
        check("flt_done_at", done_at, 33);
`else
        // Hold high T+5..T+20 restarts the pulse from T+21.
        start_req();
        observe(60, -1, 5, 20);
        check("hold_rise0", rise_at[0], 37);
        check("hold_rise0_cnt", rise_cnt[0], 1);
        check("hold_rise1", rise_at[1], 45);
        check("hold_rise2", rise_at[2], 53);
        check("hold_done_at", done_at, 54);
        check("hold_busy_fall", busy_fall, 55);
`endif

        // Request at T+20 after stage 0 is out aborts the release.
        start_req();
        observe(60, 20, -1, -1);
        check("abort_fall0", fall0_at, 21);
        check("abort_rise0_cnt", rise_cnt[0], 2);
        check("abort_rise0", rise_at[0], 37);
        check("abort_rise2", rise_at[2], 53);
        check("abort_done_cnt", done_cnt, 1);
        check("abort_done_at", done_at, 54);

        // Request during DONE: done still pulses, new sequence starts at T+34.
        start_req();
        observe(75, 33, -1, -1);
        check("dreq_done_first", done_first, 33);
        check("dreq_fall0", fall0_at, 34);
        check("dreq_rise0", rise_at[0], 50);
        check("dreq_done_cnt", done_cnt, 2);
        check("dreq_done_at", done_at, 67);
        check("dreq_busy_fall", busy_fall, 68);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
